// File: rtl/rx_block_lock_pkg.sv
// Shared widths, sync-header encodings and lock-state type for the 25G PCS receive block-lock
// stage.
package rx_block_lock_pkg;

    localparam int unsigned UNITWIDTH  = 64;
    localparam int unsigned LANENUMBER = 4;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        StUnlock,
        StSlipHold,
        StLock
    } lock_state_e;

    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_lock_fsm.sv
// One lane's sync-header block-lock state machine: lock acquisition, invalid-header window
// tracking and bit-slip requests towards the gearbox.
module rx_lock_fsm
    import rx_block_lock_pkg::*;
#(
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eval,
    input  logic [1:0] synchdr,
    output logic       lock,
    output logic       lock_next,
    output logic       slip
);

    localparam int unsigned CntW  = $clog2(LOCK_CNT + 1);
    localparam int unsigned BadW  = $clog2(INVALID_MAX + 1);
    localparam int unsigned WaitW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    localparam logic [CntW-1:0]  LockCntV    = CntW'(LOCK_CNT);
    localparam logic [BadW-1:0]  InvalidMaxV = BadW'(INVALID_MAX);
    localparam logic [WaitW-1:0] SlipWaitV   = WaitW'(SLIP_WAIT);

    lock_state_e      state_q, state_d;
    logic [CntW-1:0]  good_q, good_d;
    logic [CntW-1:0]  win_q, win_d;
    logic [BadW-1:0]  bad_q, bad_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             slip_q, slip_d;
    logic             hdr_ok;
    logic [CntW-1:0]  win_inc;
    logic [BadW-1:0]  bad_inc;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        win_d   = win_q;
        bad_d   = bad_q;
        wait_d  = wait_q;
        slip_d  = 1'b0;
        hdr_ok  = sh_valid(synchdr);
        win_inc = win_q + 1'b1;
        bad_inc = bad_q + BadW'(!hdr_ok);

        if (eval) begin
            case (state_q)
                StUnlock: begin
                    if (!hdr_ok) begin
                        slip_d  = 1'b1;
                        good_d  = '0;
                        wait_d  = SlipWaitV;
                        state_d = StSlipHold;
                    end else if (good_q == LockCntV - 1'b1) begin
                        good_d  = '0;
                        win_d   = '0;
                        bad_d   = '0;
                        state_d = StLock;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                StSlipHold: begin
                    // Gearbox is realigning; headers here carry no information.
                    if (wait_q <= WaitW'(1)) begin
                        wait_d  = '0;
                        state_d = StUnlock;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
                StLock: begin
                    // Unlock wins over the window reset when both land on the same header.
                    if (bad_inc == InvalidMaxV) begin
                        slip_d  = 1'b1;
                        win_d   = '0;
                        bad_d   = '0;
                        good_d  = '0;
                        wait_d  = SlipWaitV;
                        state_d = StSlipHold;
                    end else if (win_inc == LockCntV) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_inc;
                        bad_d = bad_inc;
                    end
                end
                default: state_d = StUnlock;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StUnlock;
            good_q  <= '0;
            win_q   <= '0;
            bad_q   <= '0;
            wait_q  <= '0;
            slip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            win_q   <= win_d;
            bad_q   <= bad_d;
            wait_q  <= wait_d;
            slip_q  <= slip_d;
        end
    end

    assign lock      = (state_q == StLock);
    assign lock_next = (state_d == StLock);
    assign slip      = slip_q;

endmodule

// File: rtl/rx_block_lock.sv
// Per-lane block-lock stage between the RX gearbox and the RX pipeline register: registers the
// data, runs one lock FSM per lane and aggregates lock into allsync.
module rx_block_lock
    import rx_block_lock_pkg::*;
#(
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_enable,
    input  logic [UNITWIDTH*LANENUMBER-1:0] in_rxdata,
    input  logic [2*LANENUMBER-1:0]         in_synchdr,
    input  logic                            in_rxdata_valid,
    output logic [UNITWIDTH*LANENUMBER-1:0] out_rxdata,
    output logic                            out_rxdata_valid,
    output logic [LANENUMBER-1:0]           out_blocklock,
    output logic                            out_allsync,
    output logic [LANENUMBER-1:0]           out_slip
);

    logic                  eval;
    logic [LANENUMBER-1:0] lock_next;

    assign eval = in_enable & in_rxdata_valid;

    for (genvar i = 0; i < LANENUMBER; i++) begin : g_lane
        rx_lock_fsm #(
            .LOCK_CNT   (LOCK_CNT),
            .INVALID_MAX(INVALID_MAX),
            .SLIP_WAIT  (SLIP_WAIT)
        ) u_fsm (
            .clk      (clk),
            .reset    (reset),
            .eval     (eval),
            .synchdr  (in_synchdr[2*i +: 2]),
            .lock     (out_blocklock[i]),
            .lock_next(lock_next[i]),
            .slip     (out_slip[i])
        );
    end

    // allsync uses next-state lock so it moves in the same cycle as out_blocklock.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_rxdata       <= '0;
            out_rxdata_valid <= 1'b0;
            out_allsync      <= 1'b0;
        end else if (in_enable) begin
            out_rxdata       <= in_rxdata;
            out_rxdata_valid <= in_rxdata_valid;
            out_allsync      <= &lock_next;
        end
    end

endmodule

// File: tb/tb_rx_block_lock.sv
// Scoreboard bench for rx_block_lock: a behavioural lane model pushes expected outputs per
// driven cycle; each scenario pops and compares after the clock edge.
module tb_rx_block_lock;
    import rx_block_lock_pkg::*;

    localparam int LN = LANENUMBER;
    localparam int DW = UNITWIDTH * LANENUMBER;
    localparam int VW = DW + 2 + 2 * LN;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_enable = 1'b0;
    logic [DW-1:0]   in_rxdata = '0;
    logic [2*LN-1:0] in_synchdr = '0;
    logic            in_rxdata_valid = 1'b0;
    logic [DW-1:0]   out_rxdata;
    logic            out_rxdata_valid;
    logic [LN-1:0]   out_blocklock;
    logic            out_allsync;
    logic [LN-1:0]   out_slip;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] sb[$];

    int            m_st[LN];
    int            m_good[LN];
    int            m_win[LN];
    int            m_bad[LN];
    int            m_wt[LN];
    logic [DW-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic [LN-1:0] m_lock = '0;
    logic          m_allsync = 1'b0;
    logic [LN-1:0] m_slip = '0;
    logic [DW-1:0] drv_data = '0;

    rx_block_lock dut (
        .clk             (clk),
        .reset           (reset),
        .in_enable       (in_enable),
        .in_rxdata       (in_rxdata),
        .in_synchdr      (in_synchdr),
        .in_rxdata_valid (in_rxdata_valid),
        .out_rxdata      (out_rxdata),
        .out_rxdata_valid(out_rxdata_valid),
        .out_blocklock   (out_blocklock),
        .out_allsync     (out_allsync),
        .out_slip        (out_slip)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] got_vec();
        return {out_rxdata, out_rxdata_valid, out_blocklock, out_allsync, out_slip};
    endfunction

    function automatic logic [2*LN-1:0] mk_hdr(input logic [LN-1:0] bad);
        logic [2*LN-1:0] h;
        for (int i = 0; i < LN; i++) begin
            if (bad[i]) h[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            else        h[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        end
        return h;
    endfunction

    // Drive one cycle, advance the model to the post-edge state and queue the expectation.
    task automatic drive(input logic rst, input logic en, input logic vld,
                         input logic [2*LN-1:0] hdr);
        logic [DW-1:0] d;
        logic [1:0]    lh;
        logic          ok;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        drv_data        = d;
        reset           = rst;
        in_enable       = en;
        in_rxdata_valid = vld;
        in_synchdr      = hdr;
        in_rxdata       = d;
        if (rst) begin
            for (int i = 0; i < LN; i++) begin
                m_st[i] = 0; m_good[i] = 0; m_win[i] = 0; m_bad[i] = 0; m_wt[i] = 0;
            end
            m_data = '0; m_valid = 1'b0; m_lock = '0; m_allsync = 1'b0; m_slip = '0;
        end else if (en) begin
            m_data  = d;
            m_valid = vld;
            m_slip  = '0;
            for (int i = 0; i < LN && vld; i++) begin
                lh = hdr[2*i +: 2];
                ok = (lh == 2'b01) || (lh == 2'b10);
                if (m_st[i] == 0) begin
                    if (ok) begin
                        m_good[i]++;
                        if (m_good[i] == 64) begin
                            m_st[i] = 2; m_good[i] = 0; m_win[i] = 0; m_bad[i] = 0;
                        end
                    end else begin
                        m_slip[i] = 1'b1; m_good[i] = 0; m_wt[i] = 4; m_st[i] = 1;
                    end
                end else if (m_st[i] == 1) begin
                    m_wt[i]--;
                    if (m_wt[i] == 0) m_st[i] = 0;
                end else begin
                    m_win[i]++;
                    if (!ok) m_bad[i]++;
                    if (m_bad[i] == 16) begin
                        m_st[i] = 1; m_slip[i] = 1'b1; m_wt[i] = 4; m_win[i] = 0; m_bad[i] = 0;
                    end else if (m_win[i] == 64) begin
                        m_win[i] = 0; m_bad[i] = 0;
                    end
                end
            end
            for (int i = 0; i < LN; i++) m_lock[i] = (m_st[i] == 2);
            m_allsync = &m_lock;
        end else begin
            m_slip = '0;
        end
        sb.push_back({m_data, m_valid, m_lock, m_allsync, m_slip});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, mk_hdr('0));
            exp = sb.pop_front();
            checks++;
            if (got_vec() !== exp) begin
                errors++;
                $display("FAIL reset cyc %0d got %h want %h", i, got_vec(), exp);
            end
        end
        checks++;
        if ({out_rxdata_valid, out_blocklock, out_allsync, out_slip} !== '0 || out_rxdata !== '0)
        begin
            errors++;
            $display("FAIL reset_zero got lock=%b slip=%b all=%b vld=%b want all 0",
                     out_blocklock, out_slip, out_allsync, out_rxdata_valid);
        end
    endtask

    task automatic test_lock_all();
        logic [VW-1:0] exp;
        for (int i = -1; i < 64; i++) begin
            drive(i < 0, 1'b1, i >= 0, mk_hdr('0));
            exp = sb.pop_front();
            checks++;
            if (got_vec() !== exp) begin
                errors++;
                $display("FAIL lock_all cyc %0d got %h want %h", i, got_vec(), exp);
            end
            if (i == 62) begin
                checks++;
                if (out_blocklock !== 4'h0) begin
                    errors++;
                    $display("FAIL lock_early got %b want 0000", out_blocklock);
                end
            end
            if (i == 63) begin
                checks++;
                if (out_blocklock !== 4'hf || out_allsync !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_64th got lock=%b all=%b want 1111/1",
                             out_blocklock, out_allsync);
                end
            end
        end
    endtask

    task automatic test_slip_lane2();
        logic [VW-1:0] exp;
        for (int i = -1; i < 71; i++) begin
            drive(i < 0, 1'b1, i >= 0, mk_hdr((i == 0) ? 4'b0100 : 4'b0000));
            exp = sb.pop_front();
            checks++;
            if (got_vec() !== exp) begin
                errors++;
                $display("FAIL slip_lane2 cyc %0d got %h want %h", i, got_vec(), exp);
            end
            if (i == 0 || i == 1) begin
                checks++;
                if (out_slip !== ((i == 0) ? 4'b0100 : 4'b0000)) begin
                    errors++;
                    $display("FAIL slip_pulse cyc %0d got %b", i, out_slip);
                end
            end
            if (i == 63 || i == 67) begin
                checks++;
                if (out_blocklock !== 4'b1011 || out_allsync !== 1'b0) begin
                    errors++;
                    $display("FAIL slip_others cyc %0d got lock=%b all=%b want 1011/0",
                             i, out_blocklock, out_allsync);
                end
            end
            if (i == 68) begin
                checks++;
                if (out_blocklock !== 4'hf || out_allsync !== 1'b1) begin
                    errors++;
                    $display("FAIL slip_relock got lock=%b all=%b want 1111/1",
                             out_blocklock, out_allsync);
                end
            end
        end
    endtask

    task automatic test_window();
        logic [VW-1:0] exp;
        logic [LN-1:0] bad;
        for (int i = -1; i < 146; i++) begin
            bad = '0;
            if (i >= 64 && i < 124 && (i % 4) == 0) bad[1] = 1'b1;
            if (i >= 128 && i < 144) bad[1] = 1'b1;
            drive(i < 0, 1'b1, i >= 0, mk_hdr(bad));
            exp = sb.pop_front();
            checks++;
            if (got_vec() !== exp) begin
                errors++;
                $display("FAIL window cyc %0d got %h want %h", i, got_vec(), exp);
            end
            if (i == 127 || i == 142) begin
                checks++;
                if (out_blocklock !== 4'hf) begin
                    errors++;
                    $display("FAIL window_hold cyc %0d got %b want 1111", i, out_blocklock);
                end
            end
            if (i == 143) begin
                checks++;
                if (out_blocklock !== 4'b1101 || out_slip !== 4'b0010 || out_allsync !== 1'b0)
                begin
                    errors++;
                    $display("FAIL window_drop got lock=%b slip=%b all=%b want 1101/0010/0",
                             out_blocklock, out_slip, out_allsync);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [VW-1:0] exp;
        logic [LN-1:0] bad;
        for (int i = -1; i < 132; i++) begin
            bad = '0;
            if (i >= 112 && i < 128) bad[3] = 1'b1;
            if (i >= 113 && i < 128) bad[0] = 1'b1;
            drive(i < 0, 1'b1, i >= 0, mk_hdr(bad));
            exp = sb.pop_front();
            checks++;
            if (got_vec() !== exp) begin
                errors++;
                $display("FAIL boundary cyc %0d got %h want %h", i, got_vec(), exp);
            end
            if (i == 127) begin
                checks++;
                if (out_blocklock !== 4'b0111 || out_slip !== 4'b1000) begin
                    errors++;
                    $display("FAIL boundary_64th got lock=%b slip=%b want 0111/1000",
                             out_blocklock, out_slip);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [VW-1:0] exp;
        logic [DW-1:0] frozen;
        logic          vld;
        logic          en;
        frozen = '0;
        for (int i = -1; i < 96; i++) begin
            vld = !(i >= 30 && i < 40);
            en  = !(i >= 74 && i < 94);
            drive(i < 0, en, vld && i >= 0, mk_hdr((vld && en) ? 4'b0000 : 4'b1111));
            if (i == 73) frozen = drv_data;
            exp = sb.pop_front();
            checks++;
            if (got_vec() !== exp) begin
                errors++;
                $display("FAIL stall cyc %0d got %h want %h", i, got_vec(), exp);
            end
            if (i == 72) begin
                checks++;
                if (out_blocklock !== 4'h0) begin
                    errors++;
                    $display("FAIL stall_early got %b want 0000", out_blocklock);
                end
            end
            if (i == 73 || i == 93) begin
                checks++;
                if (out_blocklock !== 4'hf || out_allsync !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_lock cyc %0d got lock=%b all=%b want 1111/1",
                             i, out_blocklock, out_allsync);
                end
            end
            if (i >= 74 && i < 94) begin
                checks++;
                if (out_slip !== 4'h0 || out_rxdata !== frozen) begin
                    errors++;
                    $display("FAIL stall_freeze cyc %0d got slip=%b data=%h want 0000/%h",
                             i, out_slip, out_rxdata, frozen);
                end
            end
        end
    endtask

    task automatic test_reset_in_hold();
        logic [VW-1:0] exp;
        for (int i = -1; i < 67; i++) begin
            drive(i < 0 || i == 2, 1'b1, i >= 0, mk_hdr((i == 0) ? 4'b0001 : 4'b0000));
            exp = sb.pop_front();
            checks++;
            if (got_vec() !== exp) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h want %h", i, got_vec(), exp);
            end
            if (i == 2) begin
                checks++;
                if (out_rxdata !== '0 || out_rxdata_valid !== 1'b0 || out_slip !== '0 ||
                    out_blocklock !== '0 || out_allsync !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold_zero got lock=%b slip=%b vld=%b want all 0",
                             out_blocklock, out_slip, out_rxdata_valid);
                end
            end
            if (i == 65 || i == 66) begin
                checks++;
                if (out_blocklock !== ((i == 66) ? 4'hf : 4'h0)) begin
                    errors++;
                    $display("FAIL reset_hold_relock cyc %0d got %b", i, out_blocklock);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_all();
        test_slip_lane2();
        test_window();
        test_boundary();
        test_stall();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
